fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit synchronous FIFO. It pops one byte at a time through the FIFO read port (rd_en / buf_empty / buf_out) and serialises it as an 8N1 UART frame, LSB first.
- It sits between the byte FIFO and the board-level TX pin.
- It honours the FIFO's one-cycle registered read latency and never pops an empty FIFO.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit period; legal range is 2 or more.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting new frames; it is sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag (buf_empty).
- fifo_data  input  8  FIFO read data (buf_out); valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO read strobe, exactly one cycle per byte.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever state is not IDLE.
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.
- frame_count  output  16  frames transmitted since reset; wraps 0xFFFF to 0x0000.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, busy=0, fifo_rd_en=0, frame_done=0, frame_count=0.
  - State returns to IDLE; baud counter and bit index are cleared.
- States: IDLE, LOAD, START, DATA, STOP (plus PARITY under the macro below).
- IDLE:
  - tx=1.
  - fifo_rd_en = enable && !fifo_empty (combinational, IDLE only). When it is 1, the next state is LOAD.
- LOAD:
  - Lasts one cycle. fifo_data is captured into an 8-bit shift register. Next state is START.
  - fifo_rd_en=0 in this state, so there is never a second pop before the frame ends.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shift_reg[0]. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right.
  - A 3-bit bit index counts 0 to 7. After bit 7 the next state is STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - In the final cycle: frame_done=1, frame_count increments (modulo 2^16), and the next state is IDLE.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - It counts 0 to CLKS_PER_BIT-1 and reloads to 0 on every state or bit change.
- Timing:
  - Latency from fifo_rd_en to the tx falling edge is 2 cycles: the LOAD cycle, then START begins.
  - Back-to-back frames have a period of (1+8+STOP_BITS)*CLKS_PER_BIT + 2 cycles. The 2 extra cycles (IDLE plus LOAD) have tx=1.
- Boundary conditions:
  - enable dropped mid-frame: the current frame completes unchanged, and no further pop occurs.
  - fifo_empty asserting mid-frame has no effect on the current frame.
  - fifo_empty=1 in IDLE: no pop, tx stays 1.
  - fifo_data and fifo_empty are ignored outside IDLE and LOAD.
- fifo_rd_en is never asserted while fifo_empty=1.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame period becomes (1+8+1+STOP_BITS)*CLKS_PER_BIT + 2.
- Undefined: no PARITY state; DATA goes directly to STOP (8N1).

Test Plan:
- Reset check (CLKS_PER_BIT=4): assert rst for 3 cycles -> tx=1, busy=0, fifo_rd_en=0, frame_count=0. Assert rst again mid-DATA -> tx=1 and busy=0 with no clock edge.
- Single byte 0xA5 (enable=1, fifo_empty falls for one pop):
  - Exactly one fifo_rd_en pulse.
  - tx sequence, each level 4 cycles: 0 | 1 0 1 0 0 1 0 1 | 1.
  - frame_done pulses once; frame_count=1.
- Back-to-back 0x00, 0xFF, 0x55 with FIFO pre-loaded:
  - Exactly 3 fifo_rd_en pulses, spaced 42 cycles apart.
  - frame_count=3.
  - fifo_rd_en is not asserted after fifo_empty rises.
- Empty FIFO with enable=1 for 100 cycles: fifo_rd_en never asserted, tx=1, busy=0.
- enable dropped during bit 3 of the first of two queued bytes: first frame completes bit-exact, and the second byte is not popped. Re-enabling pops it within 1 cycle.
- FIFO_UART_TX_PARITY_EN defined, bytes 0xA5 then 0x01: parity bits are 0 and 1 respectively; frame period is 46 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a sync FIFO and sends 8N1 UART frames; define FIFO_UART_TX_PARITY_EN for an even parity bit
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {
        IDLE, LOAD, START, DATA, STOP
`ifdef FIFO_UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state, state_nxt;
    logic [BW-1:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic par;
`endif
    assign baud_last = baud == BW'(CLKS_PER_BIT - 1);
    assign busy = state != IDLE;
    always_comb begin
        state_nxt = state;
        fifo_rd_en = 1'b0;
        tx = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                fifo_rd_en = enable && !fifo_empty;
                state_nxt = fifo_rd_en ? LOAD : IDLE;
            end
            LOAD: state_nxt = START;
            START: begin
                tx = 1'b0;
                state_nxt = baud_last ? DATA : START;
            end
            DATA: begin
                tx = shreg[0];
                state_nxt = (baud_last && bit_idx == 3'd7) ? AFTER_DATA : DATA;
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                tx = par;
                state_nxt = baud_last ? STOP : PARITY;
            end
`endif
            STOP: begin
                frame_done = baud_last && bit_idx == 3'(STOP_BITS - 1);
                state_nxt = frame_done ? IDLE : STOP;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // bit_idx doubles as the stop-bit counter so two stop bits need no extra state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            baud <= '0;
            bit_idx <= '0;
            shreg <= '0;
            frame_count <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            baud <= (state_nxt != state || baud_last) ? '0 : baud + 1'b1;
            bit_idx <= (state_nxt != state) ? '0 :
                       (baud_last && (state == DATA || state == STOP)) ? bit_idx + 1'b1 : bit_idx;
            if (state == LOAD)
                shreg <= fifo_data;
            else if (state == DATA && baud_last)
                shreg <= shreg >> 1;
            if (frame_done)
                frame_count <= frame_count + 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            if (state == LOAD)
                par <= ^fifo_data;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: table-driven frames against a FIFO model and frame scoreboard
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int SB = 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = (1 + 8 + int'(PAR) + SB) * CPB;
    localparam int PERIOD = FRAME + 2;
    typedef struct { logic [7:0] data; logic par; int count; } vec_t;
    typedef struct { logic [7:0] data; logic par; } exp_t;
    logic clk = 0, rst = 1, enable = 0, fifo_empty = 1, wr_en = 0, rd_s = 0;
    logic [7:0] fifo_data = 0, wr_data = 0;
    logic fifo_rd_en, tx, busy, frame_done;
    logic [15:0] frame_count;
    logic [7:0] fq[$];
    exp_t exp_q[$];
    int stamps[$];
    int n_cmp = 0, n_fail = 0, n_rd = 0, frames_model = 0, pop_empty = 0, cyc = 0;
    vec_t tbl[6];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rd_s <= fifo_rd_en;
    // FIFO model: registered read data and empty flag, one-cycle read latency
    always @(posedge clk) begin
        if (rd_s) begin
            if (fifo_empty) pop_empty <= pop_empty + 1;
            else fifo_data <= fq.pop_front();
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic lvl(input logic [7:0] d, input logic p, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return (b == 9 && PAR) ? p : 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.par = p;
        exp_q.push_back(e);
        wr_en = 1;
        wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic wait_frames(input int target);
        for (int k = 0; k < 4 * PERIOD && frames_model < target; k++) tick();
        check("frames_done", frames_model, target);
    endtask

    // monitor: each pop must be followed by the exact frame of the next scoreboard entry
    initial begin
        exp_t e;
        int bad;
        bit abort;
        forever begin
            @(negedge clk);
            if (!rst && fifo_rd_en) begin
                stamps.push_back(cyc);
                n_rd++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    bad = 0;
                    abort = 0;
                    for (int j = -1; j < FRAME; j++) begin
                        @(negedge clk);
                        if (rst) begin
                            abort = 1;
                            break;
                        end
                        if (tx !== (j < 0 ? 1'b1 : lvl(e.data, e.par, j / CPB)) || busy !== 1'b1 ||
                            fifo_rd_en !== 1'b0 || frame_done !== (j == FRAME - 1))
                            bad++;
                    end
                    if (!abort) begin
                        check($sformatf("frame_%02h", e.data), bad, 0);
                        frames_model++;
                    end
                end
            end
        end
    end

    initial begin
        int bad;
        tbl[0] = '{8'hA5, 1'b0, 1};
        tbl[1] = '{8'h01, 1'b1, 2};
        tbl[2] = '{8'h00, 1'b0, 3};
        tbl[3] = '{8'hFF, 1'b0, 4};
        tbl[4] = '{8'h55, 1'b0, 5};
        tbl[5] = '{8'h80, 1'b1, 6};
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_count", frame_count, 0);
        tick();
        rst = 0;
        enable = 1;
        for (int i = 0; i < 6; i++) begin
            push(tbl[i].data, tbl[i].par);
            wait_frames(i + 1);
            repeat (3) tick();
            @(negedge clk);
            check($sformatf("count_%02h", tbl[i].data), frame_count, tbl[i].count);
            check($sformatf("pops_%02h", tbl[i].data), n_rd, i + 1);
        end
        tick();
        enable = 0;
        stamps.delete();
        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        push(8'h55, 1'b0);
        repeat (2) tick();
        enable = 1;
        wait_frames(9);
        repeat (5) tick();
        @(negedge clk);
        check("b2b_pops", stamps.size(), 3);
        check("b2b_gap1", stamps.size() >= 3 ? stamps[1] - stamps[0] : -1, PERIOD);
        check("b2b_gap2", stamps.size() >= 3 ? stamps[2] - stamps[1] : -1, PERIOD);
        check("b2b_count", frame_count, 9);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("empty_idle_cycles", bad, 0);
        check("empty_pops", n_rd, 9);
        tick();
        enable = 0;
        push(8'h3C, 1'b0);
        push(8'hC3, 1'b0);
        repeat (2) tick();
        enable = 1;
        repeat (19) tick();
        enable = 0;
        wait_frames(10);
        repeat (20) tick();
        @(negedge clk);
        check("drop_pops", n_rd, 10);
        check("drop_fifo_kept", fifo_empty, 0);
        check("drop_busy", busy, 0);
        check("drop_count", frame_count, 10);
        tick();
        enable = 1;
        @(negedge clk);
        check("reenable_pop", fifo_rd_en, 1);
        wait_frames(11);
        push(8'h5A, 1'b0);
        bad = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                bad = 0;
                break;
            end
        end
        check("reset_frame_started", bad, 0);
        repeat (15) tick();
        check("mid_tx_low", tx, 0);
        #1 rst = 1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_count", frame_count, 0);
        repeat (2) tick();
        rst = 0;
        frames_model = 0;
        @(negedge clk);
        check("post_rst_count", frame_count, 0);
        check("pop_while_empty", pop_empty, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
